// File: rtl/decode_stage_controller.sv
// Decode-stage sequencer: owns the IF/ID register, decodes immediate-format
// controls, resolves load-use hazards and redirect squashes, and counts events.
module decode_stage_controller #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_instruction,
  input  logic [31:0]      if_pc,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             id_valid,
  output logic [31:0]      id_instruction,
  output logic [31:0]      id_pc,
  output logic [2:0]       itype,
  output logic             jal,
  output logic             jalr,
  output logic             pc_hold,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       is_jal;
  logic       is_jalr;
  logic       rs1_used;
  logic       rs2_used;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       hz;
  logic       load_ifid;
  logic       do_flush;
  logic       stall_inc;

  assign opcode = id_instruction[6:0];
  assign rs1    = id_instruction[19:15];
  assign rs2    = id_instruction[24:20];

  // Immediate-format select and register-usage decode from the ID word
  always_comb begin
    itype    = 3'b100;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OP_LOAD:   itype = 3'b000;
      OP_IMM:    itype = 3'b001;
      OP_STORE: begin
        itype    = 3'b010;
        rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        itype    = 3'b110;
        rs2_used = 1'b1;
      end
      OP_JAL: begin
        itype  = 3'b110;
        is_jal = 1'b1;
      end
      OP_JALR: begin
        itype   = 3'b110;
        is_jalr = 1'b1;
      end
      OP_REG: begin
        itype    = 3'b011;
        rs2_used = 1'b1;
      end
      default:   itype = 3'b100;
    endcase
    rs1_used = (itype != 3'b100) && !is_jal;
  end

  assign jal  = id_valid & is_jal;
  assign jalr = id_valid & is_jalr;

  // x0 never carries a real dependency, so a load targeting it cannot stall
  assign rs1_hit = rs1_used && (rs1 == ex_rd);
  assign rs2_hit = rs2_used && (rs2 == ex_rd);
  assign hz      = id_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle control; redirect beats memory freeze beats hazard
  always_comb begin
    state_next = state;
    pc_hold    = 1'b0;
    ex_bubble  = 1'b0;
    load_ifid  = 1'b0;
    do_flush   = 1'b0;
    stall_inc  = 1'b0;
    if (reset) begin
      state_next = RUN;
    end else if (ex_redirect) begin
      do_flush   = 1'b1;
      state_next = FLUSH;
    end else if (mem_busy) begin
      pc_hold = 1'b1;
    end else begin
      case (state)
        STALL: begin
          load_ifid  = 1'b1;
          state_next = RUN;
        end
        RUN, FLUSH: begin
          if (hz) begin
            pc_hold    = 1'b1;
            ex_bubble  = 1'b1;
            stall_inc  = 1'b1;
            state_next = STALL;
          end else begin
            load_ifid  = 1'b1;
            state_next = RUN;
          end
        end
        default: begin
          load_ifid  = 1'b1;
          state_next = RUN;
        end
      endcase
    end
  end

  // IF/ID pipeline register; id_pc is left alone on a squash
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid       <= 1'b0;
      id_instruction <= NOP;
      id_pc          <= RESET_PC;
    end else if (do_flush) begin
      id_valid       <= 1'b0;
      id_instruction <= NOP;
    end else if (load_ifid) begin
      id_valid       <= if_valid;
      id_instruction <= if_valid ? if_instruction : NOP;
      id_pc          <= if_pc;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (do_flush && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule
